// File: rtl/sf_param_sched.sv
`default_nettype none
// =====================================================================
// sf_param_sched: shadow-bank constant updater and frame-trigger sequencer
// Revision: 1.0
// =====================================================================
module sf_param_sched #(
  parameter int PW         = 18,
  parameter int CONST_AW   = 2,
  parameter int CONSTS_LEN = 4,
  parameter int RUN_LEN    = 40
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_trig,
  input  logic                s_write,
  input  logic [CONST_AW-1:0] s_addr,
  input  logic [PW-1:0]       s_data,
  input  logic                commit,
  output logic                trigger,
  output logic                h_write,
  output logic [CONST_AW-1:0] h_addr,
  output logic [PW-1:0]       h_data,
  output logic                busy,
  output logic                copying,
  output logic                commit_pending,
  output logic [7:0]          overrun_cnt
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_run    = 2'd1;
  localparam logic [1:0] c_st_copy   = 2'd2;
  localparam logic [7:0] c_run_init  = 8'(RUN_LEN - 1);
  localparam logic [7:0] c_copy_last = 8'(CONSTS_LEN - 1);

  logic [PW-1:0]       r_shadow [2**CONST_AW];
  logic [1:0]          r_state, w_state_nx;
  logic [7:0]          r_cnt, w_cnt_nx;
  logic [7:0]          r_ovr, w_ovr_nx;
  logic                r_defer, w_defer_nx;
  logic                r_pend, w_pend_nx;
  logic                r_trig, w_trig_nx;
  logic                r_hw, w_hw_nx;
  logic                r_busy, w_busy_nx;
  logic [CONST_AW-1:0] r_haddr, w_haddr_nx, w_rd_addr;
  logic [PW-1:0]       r_hdata, w_hdata_nx;
  logic                w_idle, w_go_copy, w_go_run, w_run_end, w_copy_end;

  // Shadow bank is deliberately unreset; reads see the pre-write value.
  always_ff @(posedge clk) begin
    if (s_write) r_shadow[s_addr] <= s_data;
  end

  assign w_idle     = (r_state == c_st_idle);
  assign w_go_copy  = w_idle && (r_pend || commit);
  assign w_go_run   = w_idle && !w_go_copy && (r_defer || frame_trig);
  assign w_run_end  = (r_state == c_st_run) && (r_cnt == 8'd0);
  assign w_copy_end = (r_state == c_st_copy) && (r_cnt == c_copy_last);
  assign w_rd_addr  = w_go_copy ? '0 : CONST_AW'(r_cnt + 8'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_go_copy)     w_state_nx = c_st_copy;
        else if (w_go_run) w_state_nx = c_st_run;
      end
      c_st_run:  if (w_run_end)  w_state_nx = c_st_idle;
      c_st_copy: if (w_copy_end) w_state_nx = c_st_idle;
      default:   w_state_nx = c_st_idle;
    endcase
  end

  always_comb begin
    w_cnt_nx   = r_cnt;
    w_trig_nx  = 1'b0;
    w_busy_nx  = 1'b0;
    w_hw_nx    = 1'b0;
    w_haddr_nx = r_haddr;
    w_hdata_nx = r_hdata;
    w_pend_nx  = r_pend;
    w_defer_nx = r_defer;
    w_ovr_nx   = r_ovr;

    if (w_go_copy || ((r_state == c_st_copy) && !w_copy_end)) begin
      w_cnt_nx   = w_go_copy ? 8'd0 : r_cnt + 8'd1;
      w_hw_nx    = 1'b1;
      w_haddr_nx = w_rd_addr;
      w_hdata_nx = r_shadow[w_rd_addr];
    end else if (w_go_run) begin
      w_cnt_nx  = c_run_init;
      w_trig_nx = 1'b1;
      w_busy_nx = 1'b1;
    end else if ((r_state == c_st_run) && !w_run_end) begin
      w_cnt_nx  = r_cnt - 8'd1;
      w_busy_nx = 1'b1;
    end

    if (w_go_copy)   w_pend_nx = 1'b0;
    else if (commit) w_pend_nx = 1'b1;

    // A trigger issued alongside a fresh frame_trig re-arms the defer slot.
    if (w_go_run) begin
      w_defer_nx = r_defer && frame_trig;
    end else if (frame_trig) begin
      if (w_idle || !r_defer)  w_defer_nx = 1'b1;
      else if (r_ovr != 8'hFF) w_ovr_nx   = r_ovr + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_ovr   <= '0;
      r_defer <= 1'b0;
      r_pend  <= 1'b0;
      r_trig  <= 1'b0;
      r_hw    <= 1'b0;
      r_busy  <= 1'b0;
      r_haddr <= '0;
      r_hdata <= '0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_ovr   <= w_ovr_nx;
      r_defer <= w_defer_nx;
      r_pend  <= w_pend_nx;
      r_trig  <= w_trig_nx;
      r_hw    <= w_hw_nx;
      r_busy  <= w_busy_nx;
      r_haddr <= w_haddr_nx;
      r_hdata <= w_hdata_nx;
    end
  end

  assign trigger        = r_trig;
  assign h_write        = r_hw;
  assign copying        = r_hw;
  assign h_addr         = r_haddr;
  assign h_data         = r_hdata;
  assign busy           = r_busy;
  assign commit_pending = r_pend;
  assign overrun_cnt    = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_sf_param_sched.sv
`default_nettype none
// Bench for sf_param_sched: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a window-based model.
module tb_sf_param_sched;
  localparam int PW = 18;
  localparam int AW = 2;
  localparam int CL = 4;
  localparam int RL = 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_trig = 1'b0;
  logic          s_write = 1'b0;
  logic [AW-1:0] s_addr = '0;
  logic [PW-1:0] s_data = '0;
  logic          commit = 1'b0;
  logic          trigger, h_write, busy, copying, commit_pending;
  logic [AW-1:0] h_addr;
  logic [PW-1:0] h_data;
  logic [7:0]    overrun_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sf_param_sched dut (
    .clk(clk), .rst_n(rst_n), .frame_trig(frame_trig), .s_write(s_write),
    .s_addr(s_addr), .s_data(s_data), .commit(commit), .trigger(trigger),
    .h_write(h_write), .h_addr(h_addr), .h_data(h_data), .busy(busy),
    .copying(copying), .commit_pending(commit_pending), .overrun_cnt(overrun_cnt)
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dx(input int v);
    logic [PW-1:0] t;
    t = PW'(v);
    return {14'd0, t};
  endfunction

  // Model: activity is a window [from, last_end]; a cycle after last_end is IDLE.
  int  n = 0, last_end = -1, run_from = 0, copy_from = 0, m_ovr = 0;
  bit  m_run = 0, m_pend = 0, m_defer = 0, m_valid = 0;
  logic [PW-1:0] sh [4];
  logic          e_trig, e_hw, e_busy;
  logic [AW-1:0] e_haddr = '0;
  logic [PW-1:0] e_hdata = '0;

  initial forever begin
    @(posedge clk);
    n++;
    if (!rst_n) begin
      m_valid = 1; last_end = n - 1; m_pend = 0; m_defer = 0; m_ovr = 0;
      m_run = 0; e_haddr = '0; e_hdata = '0;
    end else if (n - 1 > last_end) begin
      if (m_pend || commit) begin
        m_run = 0; copy_from = n; last_end = n + CL - 1; m_pend = 0;
        if (frame_trig) m_defer = 1;
      end else if (m_defer || frame_trig) begin
        m_run = 1; run_from = n; last_end = n + RL - 1;
        m_defer = m_defer && frame_trig;
      end
    end else begin
      if (commit) m_pend = 1;
      if (frame_trig) begin
        if (!m_defer) m_defer = 1;
        else if (m_ovr < 255) m_ovr++;
      end
    end
    e_trig = m_run && (n == run_from);
    e_busy = m_run && (n <= last_end);
    e_hw   = !m_run && (n <= last_end);
    if (e_hw) begin
      e_haddr = AW'(n - copy_from);
      e_hdata = sh[e_haddr];
    end
    if (s_write) sh[s_addr] = s_data;
    #1;
    if (m_valid) begin
      chk1("trigger", trigger, e_trig);
      chk1("busy", busy, e_busy);
      chk1("h_write", h_write, e_hw);
      chk1("copying", copying, e_hw);
      chk1("commit_pending", commit_pending, m_pend);
      chk32("h_addr", 32'(h_addr), 32'(e_haddr));
      chk32("h_data", 32'(h_data), 32'(e_hdata));
      chk32("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
    end
  end

  task automatic drive(input bit ft, input bit cm, input bit sw, input logic [AW-1:0] a,
                       input logic [PW-1:0] d, input bit rn = 1'b1);
    @(negedge clk);
    frame_trig = ft; commit = cm; s_write = sw; s_addr = a; s_data = d; rst_n = rn;
  endtask

  task automatic step(input bit ft, input bit cm, input bit sw, input logic [AW-1:0] a,
                      input logic [PW-1:0] d, input bit rn = 1'b1);
    drive(ft, cm, sw, a, d, rn);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    step(0, 0, 0, '0, '0, 1'b0);
    step(0, 0, 0, '0, '0, 1'b0);
    chk1("rst trigger", trigger, 1'b0);
    chk1("rst h_write", h_write, 1'b0);
    chk1("rst busy", busy, 1'b0);
    chk1("rst pending", commit_pending, 1'b0);
    chk32("rst overrun", 32'(overrun_cnt), 32'd0);
    chk32("rst h_data", 32'(h_data), 32'd0);
  endtask

  int vals[4] = '{100, -200, 300, -400};

  initial begin
    do_reset();

    // Shadow load then commit from IDLE.
    for (int i = 0; i < 4; i++) step(0, 0, 1, AW'(i), PW'(vals[i]));
    step(0, 0, 0, '0, '0);
    step(0, 1, 0, '0, '0);
    chk1("A hw0", h_write, 1'b1);
    chk1("A pend cleared", commit_pending, 1'b0);
    chk32("A addr0", 32'(h_addr), 32'd0);
    chk32("A data0", 32'(h_data), dx(100));
    for (int k = 1; k < 4; k++) begin
      step(0, 0, 0, '0, '0);
      chk32("A addr", 32'(h_addr), 32'(k));
      chk32("A data", 32'(h_data), dx(vals[k]));
    end
    step(0, 0, 0, '0, '0);
    chk1("A hw end", h_write, 1'b0);
    chk32("A addr hold", 32'(h_addr), 32'd3);
    chk32("A data hold", 32'(h_data), dx(-400));

    // Deferral and overrun.
    do_reset();
    for (int j = 0; j <= 45; j++) begin
      step(j == 0 || j == 15 || j == 25 || j == 26, 0, 0, '0, '0);
      if (j == 0)  begin chk1("B trig6", trigger, 1'b1); chk1("B busy6", busy, 1'b1); end
      if (j == 1)  chk1("B trig7", trigger, 1'b0);
      if (j == 26) chk32("B overrun", 32'(overrun_cnt), 32'd2);
      if (j == 39) chk1("B busy45", busy, 1'b1);
      if (j == 40) begin chk1("B busy46", busy, 1'b0); chk1("B trig46", trigger, 1'b0); end
      if (j == 41) chk1("B trig47", trigger, 1'b1);
    end

    // Commit during RUN waits for the run to finish.
    do_reset();
    for (int j = 0; j <= 45; j++) begin
      step(j == 0, j == 5, 0, '0, '0);
      if (j == 40) begin chk1("C hw46", h_write, 1'b0); chk1("C pend", commit_pending, 1'b1); end
      if (j == 41) begin chk1("C hw47", h_write, 1'b1); chk32("C data47", 32'(h_data), dx(100)); end
      if (j == 44) begin chk1("C hw50", h_write, 1'b1); chk32("C addr50", 32'(h_addr), 32'd3); end
      if (j == 45) chk1("C hw51", h_write, 1'b0);
    end

    // Commit and frame_trig together: copy first.
    for (int j = 0; j <= 6; j++) begin
      step(j == 0, j == 0, 0, '0, '0);
      if (j <= 3) chk1("D hw", h_write, 1'b1);
      if (j == 4) begin chk1("D hw off", h_write, 1'b0); chk1("D trig early", trigger, 1'b0); end
      if (j == 5) chk1("D trig", trigger, 1'b1);
    end

    // Shadow writes during a copy.
    do_reset();
    for (int j = 0; j <= 10; j++) begin
      if (j == 2)      step(0, 0, 1, 2'd3, PW'(7));
      else if (j == 3) step(0, 0, 1, 2'd0, PW'(9));
      else             step(0, j == 0 || j == 6, 0, '0, '0);
      if (j == 0) chk32("E data0 old", 32'(h_data), dx(100));
      if (j == 3) begin chk32("E addr3", 32'(h_addr), 32'd3); chk32("E data3", 32'(h_data), dx(7)); end
      if (j == 6) chk32("E data0 new", 32'(h_data), dx(9));
    end

    // Reset in the middle of a copy.
    for (int j = 0; j <= 6; j++) begin
      step(0, j == 0, 0, '0, '0, j != 2);
      if (j == 2) begin
        chk1("F hw", h_write, 1'b0);
        chk1("F pend", commit_pending, 1'b0);
        chk32("F addr", 32'(h_addr), 32'd0);
        chk32("F data", 32'(h_data), 32'd0);
      end
      if (j > 2) chk1("F no hw", h_write, 1'b0);
    end

    // Saturation of the overrun counter.
    do_reset();
    for (int j = 0; j < 300; j++) step(1, 0, 0, '0, '0);
    chk32("G overrun sat", 32'(overrun_cnt), 32'd255);

    // Randomized traffic, checked by the model each cycle.
    for (int j = 0; j < 3000; j++) begin
      step(($urandom % 12) == 0, ($urandom % 30) == 0, ($urandom % 3) == 0,
           AW'($urandom), PW'($urandom), ($urandom % 400) != 0);
    end
    step(0, 0, 0, '0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
